// File: rtl/reg_bank_sequencer.sv
// -----------------------------------------------------------------------------
// reg_bank_sequencer
//
// Purpose: runs one read-out pass over a small register bank (A, B, C).
// A start request latches a 3-bit mask, pulses the load strobes for the
// selected registers, then walks the selected registers in A, B, C order.
// For each one it drives the bank mux select, waits SETTLE cycles, captures
// the mux output and offers it on a valid/ready output port.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   start       pass request, only looked at while idle
//   mask[2:0]   bit0=A, bit1=B, bit2=C, latched together with start
//   ld_a/b/c    one-cycle load strobes to the register bank
//   output_sel  bank mux select: 00=A, 01=B, 10=C, 11=zeros (parked)
//   data_in     bank mux output
//   word_out    captured word
//   word_tag    select value the word was captured under
//   word_valid  / word_ready  output handshake
//   last        marks the final word of a pass (qualified by word_valid)
//   busy        high whenever a pass is in progress
//   done        one-cycle pulse closing a pass
//   dbg_state   current FSM state, for observation only
//
// Handshake: a word transfers on every rising edge where word_valid and
// word_ready are both 1. Once word_valid rises, word_out, word_tag and last
// hold their values until that transfer edge; word_valid never drops
// without a transfer (except on reset).
// -----------------------------------------------------------------------------
module reg_bank_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mask,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_c,
  output logic [1:0]  output_sel,
  input  logic [15:0] data_in,
  output logic [15:0] word_out,
  output logic [1:0]  word_tag,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        last,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SELECT = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [1:0] SEL_PARK    = 2'b11;

  state_t     state;
  logic [2:0] rem;         // registers still to be read in this pass
  logic [3:0] settle_cnt;
  logic [2:0] rem_after;   // rem with the register currently selected removed

  // Lowest-index set bit of m; 11 when nothing is left.
  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      return 2'b00;
    else if (m[1]) return 2'b01;
    else if (m[2]) return 2'b10;
    else           return 2'b11;
  endfunction

  // One-hot mask bit for a select value; the parked select maps to nothing.
  function automatic logic [2:0] sel_bit(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign rem_after = rem & ~sel_bit(output_sel);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= 3'b000;
      settle_cnt <= 4'd0;
      ld_a       <= 1'b0;
      ld_b       <= 1'b0;
      ld_c       <= 1'b0;
      output_sel <= SEL_PARK;
      word_out   <= 16'h0000;
      word_tag   <= 2'b00;
      word_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes default low so they only ever last one cycle.
      ld_a <= 1'b0;
      ld_b <= 1'b0;
      ld_c <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (mask != 3'b000) begin
              rem   <= mask;
              ld_a  <= mask[0];
              ld_b  <= mask[1];
              ld_c  <= mask[2];
              state <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          output_sel <= lowest(rem);
          settle_cnt <= 4'd0;
          state      <= SELECT;
        end
        SELECT: begin
          if (settle_cnt == SETTLE_LAST) begin
            // Only register C is a full 16-bit word; A and B are bytes.
            word_out   <= (output_sel == 2'b10) ? data_in : {8'h00, data_in[7:0]};
            word_tag   <= output_sel;
            last       <= (rem_after == 3'b000);
            word_valid <= 1'b1;
            state      <= SEND;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SEND: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            last       <= 1'b0;
            rem        <= rem_after;
            if (rem_after != 3'b000) begin
              output_sel <= lowest(rem_after);
              settle_cnt <= 4'd0;
              state      <= SELECT;
            end else begin
              output_sel <= SEL_PARK;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          output_sel <= SEL_PARK;
          word_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_sequencer
//
// Two instances share all stimulus: lane 0 with SETTLE=1, lane 1 with
// SETTLE=3. Each lane has a constant register bank behind its mux. A
// pass-level model predicts, per cycle, the words still owed, when the next
// word becomes visible, the load strobe cycle and the done cycle; a single
// compare process checks both lanes every cycle. Directed tests then pin the
// model with hand-computed cycle numbers and words taken from logs of what
// the DUT actually emitted.
//
// Cycle numbering: cycle n is the clock period after the n-th rising edge.
// Inputs change 1 time unit after a rising edge, outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_reg_bank_sequencer;

  localparam logic [15:0] BANK_A = 16'h125A;
  localparam logic [15:0] BANK_B = 16'hABC3;
  localparam logic [15:0] BANK_C = 16'hBEEF;

  typedef struct {
    int          cyc;
    logic [15:0] w;
    logic [1:0]  t;
    logic        l;
  } ev_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, start, word_ready;
  logic [2:0] mask;

  logic [1:0]       ld_a, ld_b, ld_c, word_valid, last, busy, done;
  logic [1:0][1:0]  output_sel, word_tag;
  logic [1:0][15:0] data_in, word_out;
  logic [1:0][2:0]  dbg_state;

  always #5 clk = ~clk;

  function automatic logic [15:0] bank(input logic [1:0] s);
    case (s)
      2'b00:   return BANK_A;
      2'b01:   return BANK_B;
      2'b10:   return BANK_C;
      default: return 16'h0000;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    reg_bank_sequencer #(.SETTLE(g == 0 ? 1 : 3)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .mask(mask),
      .ld_a(ld_a[g]),
      .ld_b(ld_b[g]),
      .ld_c(ld_c[g]),
      .output_sel(output_sel[g]),
      .data_in(data_in[g]),
      .word_out(word_out[g]),
      .word_tag(word_tag[g]),
      .word_valid(word_valid[g]),
      .word_ready(word_ready),
      .last(last[g]),
      .busy(busy[g]),
      .done(done[g]),
      .dbg_state(dbg_state[g])
    );
    assign data_in[g] = bank(output_sel[g]);
  end

  // ---------------- counters and checking ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int l, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, l, $time, act, exp);
    end
  endtask

  function automatic int settle_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] first_reg(input logic [2:0] m);
    for (int b = 0; b < 3; b++) if (m[b]) return 2'(b);
    return 2'b11;
  endfunction

  // ---------------- pass-level model ----------------
  int         cyc = 0;
  logic       m_busy[2]      = '{1'b0, 1'b0};
  logic [2:0] m_rem[2]       = '{3'b000, 3'b000};
  logic [2:0] m_ld_mask[2]   = '{3'b000, 3'b000};
  int         m_valid_cyc[2] = '{0, 0};
  int         m_done_cyc[2]  = '{-1, -1};
  int         m_ld_cyc[2]    = '{-1, -1};

  // Evaluates the cycle that is ending at this edge, then advances cyc.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        m_busy[l]     = 1'b0;
        m_rem[l]      = 3'b000;
        m_done_cyc[l] = -1;
        m_ld_cyc[l]   = -1;
      end else if (!m_busy[l]) begin
        if (start) begin
          m_busy[l] = 1'b1;
          if (mask == 3'b000) begin
            m_done_cyc[l] = cyc + 1;
          end else begin
            m_rem[l]       = mask;
            m_ld_mask[l]   = mask;
            m_ld_cyc[l]    = cyc + 1;
            // load cycle, SETTLE select cycles, then the word is visible
            m_valid_cyc[l] = cyc + 2 + settle_of(l);
          end
        end
      end else if (m_rem[l] != 3'b000 && cyc >= m_valid_cyc[l] && word_ready) begin
        m_rem[l] = m_rem[l] & (m_rem[l] - 3'd1);
        if (m_rem[l] == 3'b000) m_done_cyc[l] = cyc + 1;
        else                    m_valid_cyc[l] = cyc + 1 + settle_of(l);
      end else if (cyc == m_done_cyc[l]) begin
        m_busy[l] = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- logs of observed DUT behaviour ----------------
  ev_t        hs0[$], hs1[$];
  int         done0[$], done1[$];
  logic [2:0] ld_or[2]     = '{3'b000, 3'b000};
  int         valid_cnt[2] = '{0, 0};
  int         sel01_cnt[2] = '{0, 0};

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int l = 0; l < 2; l++) begin
        logic        exp_valid, exp_last, exp_done;
        logic [1:0]  exp_tag;
        logic [15:0] raw, exp_word;
        logic [2:0]  exp_ld;
        ev_t         ev;
        exp_valid = m_busy[l] && (m_rem[l] != 3'b000) && (cyc >= m_valid_cyc[l]);
        exp_tag   = first_reg(m_rem[l]);
        exp_last  = ((m_rem[l] & (m_rem[l] - 3'd1)) == 3'b000);
        raw       = bank(exp_tag);
        exp_word  = (exp_tag == 2'b10) ? raw : {8'h00, raw[7:0]};
        exp_ld    = (cyc == m_ld_cyc[l]) ? m_ld_mask[l] : 3'b000;
        exp_done  = m_busy[l] && (cyc == m_done_cyc[l]);

        check("word_valid", l, 32'(word_valid[l]), 32'(exp_valid));
        if (exp_valid) begin
          check("word_out", l, 32'(word_out[l]), 32'(exp_word));
          check("word_tag", l, 32'(word_tag[l]), 32'(exp_tag));
          check("last", l, 32'(last[l]), 32'(exp_last));
        end
        check("ld_strobes", l, 32'({ld_c[l], ld_b[l], ld_a[l]}), 32'(exp_ld));
        check("busy", l, 32'(busy[l]), 32'(m_busy[l]));
        check("done", l, 32'(done[l]), 32'(exp_done));
        if (!m_busy[l] || cyc == m_done_cyc[l])
          check("output_sel_parked", l, 32'(output_sel[l]), 32'h3);
        else if (m_rem[l] != 3'b000 && cyc >= m_valid_cyc[l] - settle_of(l))
          check("output_sel", l, 32'(output_sel[l]), 32'(exp_tag));

        ld_or[l] = ld_or[l] | {ld_c[l], ld_b[l], ld_a[l]};
        if (word_valid[l]) valid_cnt[l]++;
        if (output_sel[l] == 2'b01 && !word_valid[l]) sel01_cnt[l]++;
        if (word_valid[l] && word_ready) begin
          ev.cyc = cyc; ev.w = word_out[l]; ev.t = word_tag[l]; ev.l = last[l];
          if (l == 0) hs0.push_back(ev); else hs1.push_back(ev);
        end
        if (done[l]) begin
          if (l == 0) done0.push_back(cyc); else done1.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    hs0.delete(); hs1.delete(); done0.delete(); done1.delete();
    for (int l = 0; l < 2; l++) begin
      ld_or[l] = 3'b000; valid_cnt[l] = 0; sel01_cnt[l] = 0;
    end
  endtask

  // Leaves the bench in the load cycle; returns its cycle number.
  task automatic pulse_start(input logic [2:0] m, output int e);
    mask  = m;
    start = 1'b1;
    step(1);
    start = 1'b0;
    e = cyc;
  endtask

  task automatic check_hs(input int l, input int idx, input int exp_cyc,
                          input logic [15:0] w, input logic [1:0] t, input logic lst);
    ev_t ev;
    int  sz;
    sz = (l == 0) ? hs0.size() : hs1.size();
    if (idx >= sz) begin
      check("word_count", l, 32'(sz), 32'(idx + 1));
    end else begin
      ev = (l == 0) ? hs0[idx] : hs1[idx];
      check("word_cycle", l, 32'(ev.cyc), 32'(exp_cyc));
      check("word_value", l, 32'(ev.w), 32'(w));
      check("word_tag_lit", l, 32'(ev.t), 32'(t));
      check("word_last_lit", l, 32'(ev.l), 32'(lst));
    end
  endtask

  task automatic check_reset_values();
    for (int l = 0; l < 2; l++) begin
      check("rst_word_out", l, 32'(word_out[l]), 32'h0);
      check("rst_word_tag", l, 32'(word_tag[l]), 32'h0);
      check("rst_last", l, 32'(last[l]), 32'h0);
      check("rst_valid", l, 32'(word_valid[l]), 32'h0);
      check("rst_busy", l, 32'(busy[l]), 32'h0);
      check("rst_done", l, 32'(done[l]), 32'h0);
      check("rst_sel", l, 32'(output_sel[l]), 32'h3);
      check("rst_ld", l, 32'({ld_c[l], ld_b[l], ld_a[l]}), 32'h0);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int e;
    reset = 1'b1; start = 1'b0; mask = 3'b000; word_ready = 1'b1;
    step(3);
    check_reset_values();
    reset = 1'b0;
    step(2);

    // Full pass, ready high: words in cycles 3/5/7 when the load cycle is 1.
    clear_logs();
    pulse_start(3'b111, e);
    step(16);
    check_hs(0, 0, e + 2, 16'h005A, 2'b00, 1'b0);
    check_hs(0, 1, e + 4, 16'h00C3, 2'b01, 1'b0);
    check_hs(0, 2, e + 6, 16'hBEEF, 2'b10, 1'b1);
    check("done_count", 0, 32'(done0.size()), 32'd1);
    if (done0.size() > 0) check("done_cycle", 0, 32'(done0[0]), 32'(e + 7));
    check_hs(1, 2, e + 12, 16'hBEEF, 2'b10, 1'b1);
    check("ld_seen", 0, 32'(ld_or[0]), 32'h7);

    // A and C only, first word stalled four cycles.
    clear_logs();
    pulse_start(3'b101, e);
    step(2);
    word_ready = 1'b0;
    step(4);
    word_ready = 1'b1;
    step(10);
    check_hs(0, 0, e + 6, 16'h005A, 2'b00, 1'b0);
    check_hs(0, 1, e + 8, 16'hBEEF, 2'b10, 1'b1);
    check("valid_cycles", 0, 32'(valid_cnt[0]), 32'd6);
    check("ld_seen", 0, 32'(ld_or[0]), 32'h5);
    check("ld_seen", 1, 32'(ld_or[1]), 32'h5);
    if (done0.size() > 0) check("done_cycle", 0, 32'(done0[0]), 32'(e + 9));
    else check("done_count", 0, 32'd0, 32'd1);

    // Empty mask: done in the cycle after start, nothing else.
    clear_logs();
    pulse_start(3'b000, e);
    step(4);
    check("word_count", 0, 32'(hs0.size()), 32'd0);
    check("valid_cycles", 0, 32'(valid_cnt[0]), 32'd0);
    check("ld_seen", 0, 32'(ld_or[0]), 32'h0);
    check("done_count", 0, 32'(done0.size()), 32'd1);
    if (done0.size() > 0) check("done_cycle", 0, 32'(done0[0]), 32'(e));

    // B only; lane 1 holds select 01 for three cycles before its word.
    clear_logs();
    pulse_start(3'b010, e);
    step(8);
    check_hs(1, 0, e + 4, 16'h00C3, 2'b01, 1'b1);
    check("sel01_before_valid", 1, 32'(sel01_cnt[1]), 32'd3);
    check("sel01_before_valid", 0, 32'(sel01_cnt[0]), 32'd1);
    check("word_count", 1, 32'(hs1.size()), 32'd1);

    // Reset during the second word's SEND with start held high.
    clear_logs();
    mask  = 3'b111;
    start = 1'b1;
    step(1);
    e = cyc;
    step(4);
    word_ready = 1'b0;
    reset = 1'b1;
    step(1);
    check_reset_values();
    step(1);
    reset = 1'b0;
    word_ready = 1'b1;
    check("word_count_abort", 0, 32'(hs0.size()), 32'd1);
    check("done_count_abort", 0, 32'(done0.size()), 32'd0);
    check("done_count_abort", 1, 32'(done1.size()), 32'd0);
    step(1);
    start = 1'b0;
    step(16);
    check_hs(0, 1, e + 9, 16'h005A, 2'b00, 1'b0);
    check_hs(0, 3, e + 13, 16'hBEEF, 2'b10, 1'b1);
    if (done0.size() > 0) check("done_cycle", 0, 32'(done0[0]), 32'(e + 14));
    else check("done_count", 0, 32'd0, 32'd1);

    // Start while busy is dropped; mask changes mid-pass have no effect.
    clear_logs();
    pulse_start(3'b011, e);
    step(2);
    mask  = 3'b100;
    start = 1'b1;
    step(1);
    start = 1'b0;
    mask  = 3'b111;
    step(14);
    check_hs(0, 0, e + 2, 16'h005A, 2'b00, 1'b0);
    check_hs(0, 1, e + 4, 16'h00C3, 2'b01, 1'b1);
    check("word_count", 0, 32'(hs0.size()), 32'd2);
    check("word_count", 1, 32'(hs1.size()), 32'd2);
    check("done_count", 0, 32'(done0.size()), 32'd1);
    check("done_count", 1, 32'(done1.size()), 32'd1);
    check("ld_seen", 0, 32'(ld_or[0]), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
